// File: rtl/i2c_config_sequencer.sv
// rtl/i2c_config_sequencer.sv - walks a register table and issues one I2C write per entry
//
// Ports:
//   CLOCK      in   1   sequencer clock (shared with i2c_controller)
//   RESET      in   1   asynchronous active-low reset
//   HPD        in   1   hot-plug detect, asynchronous, double-flopped here
//   LUT_DATA   in   24  table word addressed by LUT_INDEX, valid same cycle
//   LUT_INDEX  out  6   current table index
//   I2C_DATA   out  24  registered {slave,reg,data} word to i2c_controller
//   GO         out  1   transfer request, high only in REQ
//   END        in   1   controller idle/complete (1 = idle)
//   ACK        in   1   1 = every byte of the last transfer was acknowledged
//   DONE       out  1   table fully written since last (re)start
//   ERR        out  1   sticky: an entry ran out of retries; cleared on restart
module i2c_config_sequencer #(
    parameter int LUT_SIZE   = 31,
    parameter int PWR_DELAY  = 50000,
    parameter int GAP_CYCLES = 16,
    parameter int MAX_RETRY  = 3,
    parameter int TIMEOUT    = 65535
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        HPD,
    input  logic [23:0] LUT_DATA,
    output logic [5:0]  LUT_INDEX,
    output logic [23:0] I2C_DATA,
    output logic        GO,
    input  logic        END,
    input  logic        ACK,
    output logic        DONE,
    output logic        ERR
);

    // Delay lengths are clamped to at least one cycle so the "last count"
    // constants below never underflow.
    localparam int PWR_N   = (PWR_DELAY  < 1) ? 1 : PWR_DELAY;
    localparam int GAP_N   = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int DLY_MAX = (PWR_N > GAP_N) ? PWR_N : GAP_N;
    localparam int DW      = $clog2(DLY_MAX + 1);
    localparam int RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [DW-1:0] PWR_LAST = DW'(PWR_N - 1);
    localparam logic [DW-1:0] GAP_LAST = DW'(GAP_N - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [16:0]   TMO       = 17'(TIMEOUT);
    localparam logic [5:0]    LAST_IDX  = 6'(LUT_SIZE - 1);

    typedef enum logic [3:0] {
        S_WAIT_HPD,
        S_PWR_WAIT,
        S_LOAD,
        S_REQ,
        S_BUSY,
        S_CHECK,
        S_FAIL,
        S_NEXT,
        S_GAP,
        S_RUN
    } state_t;

    state_t          state, state_nx;
    logic            hpd_meta, hpd_s;
    logic [DW-1:0]   dly_cnt;
    logic [16:0]     tmo_cnt;
    logic [RW-1:0]   retry;
    logic [5:0]      idx;
    logic [23:0]     data;
    logic            done_r, err_r;
    logic            gap_to_req;   // GAP exit target: 1 = REQ (retry), 0 = LOAD (next entry)
    logic            hpd_drop;     // HPD went low while a transfer was in flight
    logic            hpd_lost;

    logic ld_data, clr_retry, inc_retry, idx_clr, idx_inc;
    logic set_err, set_done, clr_done, clr_status;
    logic gap_sel_we, gap_sel;

    assign hpd_lost  = hpd_drop | ~hpd_s;
    assign GO        = (state == S_REQ);
    assign LUT_INDEX = idx;
    assign I2C_DATA  = data;
    assign DONE      = done_r;
    assign ERR       = err_r;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            hpd_meta <= 1'b0;
            hpd_s    <= 1'b0;
        end else begin
            hpd_meta <= HPD;
            hpd_s    <= hpd_meta;
        end
    end

    // Both counters restart on every state change and saturate otherwise.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            dly_cnt <= '0;
            tmo_cnt <= '0;
        end else if (state_nx != state) begin
            dly_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (dly_cnt != '1) dly_cnt <= dly_cnt + 1'b1;
            if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_WAIT_HPD;
            idx        <= '0;
            data       <= '0;
            retry      <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            gap_to_req <= 1'b0;
            hpd_drop   <= 1'b0;
        end else begin
            state <= state_nx;
            if (idx_clr)
                idx <= '0;
            else if (idx_inc && idx != LAST_IDX)
                idx <= idx + 6'd1;
            if (ld_data)
                data <= LUT_DATA;
            if (clr_retry)
                retry <= '0;
            else if (inc_retry)
                retry <= retry + 1'b1;
            if (clr_status) begin
                done_r <= 1'b0;
                err_r  <= 1'b0;
            end else begin
                if (set_err)  err_r  <= 1'b1;
                if (set_done) done_r <= 1'b1;
                if (clr_done) done_r <= 1'b0;
            end
            if (gap_sel_we)
                gap_to_req <= gap_sel;
            if (state == S_WAIT_HPD)
                hpd_drop <= 1'b0;
            else if ((state == S_REQ || state == S_BUSY) && !hpd_s)
                hpd_drop <= 1'b1;
        end
    end

    always_comb begin
        state_nx   = state;
        ld_data    = 1'b0;
        clr_retry  = 1'b0;
        inc_retry  = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        set_err    = 1'b0;
        set_done   = 1'b0;
        clr_done   = 1'b0;
        clr_status = 1'b0;
        gap_sel_we = 1'b0;
        gap_sel    = 1'b0;
        case (state)
            S_WAIT_HPD: begin
                if (hpd_s) begin
                    clr_status = 1'b1;
                    state_nx   = S_PWR_WAIT;
                end
            end
            S_PWR_WAIT: begin
                if (!hpd_s)
                    state_nx = S_WAIT_HPD;
                else if (dly_cnt >= PWR_LAST) begin
                    idx_clr  = 1'b1;
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!hpd_s)
                    state_nx = S_WAIT_HPD;
                else begin
                    ld_data   = 1'b1;
                    clr_retry = 1'b1;
                    state_nx  = S_REQ;
                end
            end
            // A transfer in flight is always allowed to finish, even if HPD
            // drops; the drop is acted on once it is over.
            S_REQ: begin
                if (!END)
                    state_nx = S_BUSY;
                else if (tmo_cnt == TMO)
                    state_nx = S_FAIL;
            end
            S_BUSY: begin
                if (END)
                    state_nx = S_CHECK;
                else if (tmo_cnt == TMO)
                    state_nx = S_FAIL;
            end
            S_CHECK: begin
                if (hpd_lost)
                    state_nx = S_WAIT_HPD;
                else if (ACK)
                    state_nx = S_NEXT;
                else
                    state_nx = S_FAIL;
            end
            S_FAIL: begin
                if (hpd_lost)
                    state_nx = S_WAIT_HPD;
                else if (retry < RETRY_MAX) begin
                    inc_retry  = 1'b1;
                    gap_sel_we = 1'b1;
                    gap_sel    = 1'b1;
                    state_nx   = S_GAP;
                end else begin
                    set_err  = 1'b1;
                    state_nx = S_NEXT;
                end
            end
            S_NEXT: begin
                if (hpd_lost)
                    state_nx = S_WAIT_HPD;
                else if (idx == LAST_IDX) begin
                    set_done = 1'b1;
                    state_nx = S_RUN;
                end else begin
                    idx_inc    = 1'b1;
                    gap_sel_we = 1'b1;
                    gap_sel    = 1'b0;
                    state_nx   = S_GAP;
                end
            end
            // Leaving GAP also waits for END=1: after a BUSY timeout the
            // controller may still be busy, and GO must not rise until it idles.
            S_GAP: begin
                if (!hpd_s)
                    state_nx = S_WAIT_HPD;
                else if (dly_cnt >= GAP_LAST && END)
                    state_nx = gap_to_req ? S_REQ : S_LOAD;
            end
            S_RUN: begin
                if (!hpd_s) begin
                    clr_done = 1'b1;
                    state_nx = S_WAIT_HPD;
                end
            end
            default: state_nx = S_WAIT_HPD;
        endcase
    end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb/tb_i2c_config_sequencer.sv - randomized bench for i2c_config_sequencer against a table-level model
module tb_i2c_config_sequencer;

    localparam int LUT_SIZE   = 4;
    localparam int PWR_DELAY  = 50;
    localparam int GAP_CYCLES = 16;
    localparam int MAX_RETRY  = 3;
    localparam int TIMEOUT    = 100;
    localparam int ALWAYS     = 255;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        HPD;
    logic [23:0] LUT_DATA;
    logic [5:0]  LUT_INDEX;
    logic [23:0] I2C_DATA;
    logic        GO;
    logic        END;
    logic        ACK;
    logic        DONE;
    logic        ERR;

    logic [23:0] lut [0:LUT_SIZE-1];
    int          nack_cnt [0:LUT_SIZE-1];
    int          att [0:63];
    bit          stuck;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    logic [23:0] obs_data [$];
    int          obs_idx  [$];
    bit          go_q = 1'b0;
    int          go_hi = 0;
    int          idle_cnt = 0;
    bit          first_seen;
    int          first_go_cyc;
    int          hpd_cyc;

    i2c_config_sequencer #(
        .LUT_SIZE  (LUT_SIZE),
        .PWR_DELAY (PWR_DELAY),
        .GAP_CYCLES(GAP_CYCLES),
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .HPD      (HPD),
        .LUT_DATA (LUT_DATA),
        .LUT_INDEX(LUT_INDEX),
        .I2C_DATA (I2C_DATA),
        .GO       (GO),
        .END      (END),
        .ACK      (ACK),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    assign LUT_DATA = lut[LUT_INDEX[1:0]];

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // I2C controller model: acknowledges attempt k of an entry iff k >= nack_cnt.
    initial begin
        int  k;
        bit  ack_now;
        END = 1'b1;
        ACK = 1'b0;
        forever begin
            @(negedge CLOCK);
            if (GO && END && !stuck) begin
                k       = int'(LUT_INDEX);
                ack_now = (att[k] >= nack_cnt[k & 3]);
                att[k]  = att[k] + 1;
                repeat (2) @(negedge CLOCK);
                END = 1'b0;
                repeat (20) @(negedge CLOCK);
                ACK = ack_now;
                END = 1'b1;
            end
        end
    end

    // Bus monitor: logs every GO request and checks handshake spacing.
    always @(negedge CLOCK) begin
        if (GO && !go_q) begin
            obs_data.push_back(I2C_DATA);
            obs_idx.push_back(int'(LUT_INDEX));
            chk("go_while_busy", END, 1);
            chk("gap_len", (idle_cnt >= GAP_CYCLES), 1);
            if (!first_seen) begin
                first_seen   = 1'b1;
                first_go_cyc = cyc;
            end
            go_hi    = 0;
            idle_cnt = 0;
        end
        if (GO) go_hi++;
        if (!GO && go_q && stuck) chk("go_len", go_hi, TIMEOUT + 1);
        if (!GO && END) idle_cnt++;
        go_q = GO;
    end

    task automatic clear_log();
        obs_data.delete();
        obs_idx.delete();
        for (int i = 0; i < 64; i++) att[i] = 0;
        first_seen = 1'b0;
    endtask

    task automatic new_table();
        for (int i = 0; i < LUT_SIZE; i++) begin
            lut[i]      = 24'($urandom);
            nack_cnt[i] = 0;
        end
    endtask

    task automatic start_seq();
        HPD = 1'b0;
        repeat (8) @(negedge CLOCK);
        chk("done_clr_on_hpd_low", DONE, 0);
        clear_log();
        @(negedge CLOCK);
        HPD     = 1'b1;
        hpd_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!DONE && n < budget) begin
            @(negedge CLOCK);
            n++;
        end
        chk("done_reached", DONE, 1);
    endtask

    // Expected transfer list straight from the table rules.
    task automatic verify(input string tag);
        logic [23:0] exp_data [$];
        int          exp_idx  [$];
        bit          exp_err = 1'b0;
        int          n, a, m;
        for (int i = 0; i < LUT_SIZE; i++) begin
            n = stuck ? ALWAYS : nack_cnt[i];
            a = (n > MAX_RETRY) ? MAX_RETRY + 1 : n + 1;
            if (n > MAX_RETRY) exp_err = 1'b1;
            for (int j = 0; j < a; j++) begin
                exp_data.push_back(lut[i]);
                exp_idx.push_back(i);
            end
        end
        chk({tag, "_count"}, obs_data.size(), exp_data.size());
        m = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
        for (int k = 0; k < m; k++) begin
            chk({tag, "_data"}, obs_data[k], exp_data[k]);
            chk({tag, "_idx"}, obs_idx[k], exp_idx[k]);
        end
        chk({tag, "_err"}, ERR, exp_err);
        chk({tag, "_done"}, DONE, 1);
        chk({tag, "_last_idx"}, LUT_INDEX, LUT_SIZE - 1);
        chk({tag, "_first_go"}, first_go_cyc - hpd_cyc, PWR_DELAY + 4);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RESET = 1'b0;
        HPD   = 1'b0;
        stuck = 1'b0;
        clear_log();
        new_table();
        repeat (3) @(negedge CLOCK);
        chk("rst_go", GO, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_idx", LUT_INDEX, 0);
        chk("rst_data", I2C_DATA, 0);
        RESET = 1'b1;

        // 1: clean pass
        start_seq();
        wait_done(5000);
        verify("t1");

        // 2: entry 2 NACKs twice
        new_table();
        nack_cnt[2] = 2;
        start_seq();
        wait_done(5000);
        verify("t2");

        // 3: entry 1 never acknowledges
        new_table();
        nack_cnt[1] = ALWAYS;
        start_seq();
        wait_done(5000);
        verify("t3");

        // random NACK patterns
        for (int r = 0; r < 3; r++) begin
            new_table();
            for (int i = 0; i < LUT_SIZE; i++) nack_cnt[i] = $urandom_range(0, 5);
            start_seq();
            wait_done(6000);
            verify("rnd");
        end

        // 4: controller never leaves idle
        new_table();
        stuck = 1'b1;
        start_seq();
        wait_done(8000);
        verify("t4");
        stuck = 1'b0;

        // 5: HPD drops in BUSY of entry 3, which would NACK
        new_table();
        nack_cnt[1] = ALWAYS;
        nack_cnt[3] = 1;
        start_seq();
        n = 0;
        while (!(GO && LUT_INDEX == 6'd3) && n < 4000) begin
            @(negedge CLOCK);
            n++;
        end
        chk("t5_reach_e3", GO && LUT_INDEX == 6'd3, 1);
        n = 0;
        while (END && n < 50) begin
            @(negedge CLOCK);
            n++;
        end
        chk("t5_busy", END, 0);
        HPD = 1'b0;
        repeat (60) @(negedge CLOCK);
        chk("t5_e3_attempts", att[3], 1);
        chk("t5_done", DONE, 0);
        chk("t5_err_sticky", ERR, 1);
        chk("t5_count", obs_data.size(), 1 + (MAX_RETRY + 1) + 1 + 1);
        repeat (40) @(negedge CLOCK);
        chk("t5_no_go", GO, 0);
        clear_log();
        for (int i = 0; i < LUT_SIZE; i++) nack_cnt[i] = 0;
        HPD     = 1'b1;
        hpd_cyc = cyc;
        repeat (6) @(negedge CLOCK);
        chk("t5_err_cleared", ERR, 0);
        wait_done(5000);
        verify("t5");

        // 6: reset pulse mid-BUSY
        new_table();
        nack_cnt[0] = ALWAYS;
        start_seq();
        n = 0;
        while (!(GO && LUT_INDEX == 6'd2) && n < 4000) begin
            @(negedge CLOCK);
            n++;
        end
        n = 0;
        while (END && n < 50) begin
            @(negedge CLOCK);
            n++;
        end
        chk("t6_busy", END, 0);
        chk("t6_err_pre", ERR, 1);
        #3;
        RESET = 1'b0;
        #1;
        chk("t6_go", GO, 0);
        chk("t6_done", DONE, 0);
        chk("t6_err", ERR, 0);
        chk("t6_idx", LUT_INDEX, 0);
        @(negedge CLOCK);
        clear_log();
        for (int i = 0; i < LUT_SIZE; i++) nack_cnt[i] = 0;
        RESET   = 1'b1;
        hpd_cyc = cyc;
        wait_done(5000);
        verify("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
